// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the cpu run/step/halt controller.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        BREAK = 2'd3
    } ctrl_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/cpu_run_ctrl_btn_sync.sv
// Button synchroniser: SYNC_STAGES-flop synchroniser followed by a
// rising-edge detector, giving one clean single-cycle pulse per press.
module btn_sync
    import cpu_ctrl_pkg::*;
(
    input  logic clk,
    input  logic n_reset,
    input  logic btn,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Synchronise the raw button and remember the last synchronised level.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign pulse = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer with hardware PC breakpoint; gates the cpu
// clock-enable and counts executed instructions.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int pw = 5,
    parameter int cw = 16
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          btn_run,
    input  logic          btn_step,
    input  logic          btn_halt,
    input  logic          clr_count,
    input  logic          bp_en,
    input  logic [pw-1:0] bp_addr,
    input  logic [pw-1:0] pc_in,
    output logic          cpu_en,
    output logic [1:0]    state,
    output logic          bp_hit,
    output logic [cw-1:0] instr_count
);

    ctrl_state_t cur_state;
    ctrl_state_t nxt_state;
    logic        run_pulse;
    logic        step_pulse;
    logic        halt_pulse;
    logic        skip;
    logic        skip_set;
    logic        match;

    btn_sync u_sync_run (
        .clk     (clk),
        .n_reset (n_reset),
        .btn     (btn_run),
        .pulse   (run_pulse)
    );

    btn_sync u_sync_step (
        .clk     (clk),
        .n_reset (n_reset),
        .btn     (btn_step),
        .pulse   (step_pulse)
    );

    btn_sync u_sync_halt (
        .clk     (clk),
        .n_reset (n_reset),
        .btn     (btn_halt),
        .pulse   (halt_pulse)
    );

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cur_state <= HALT;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Breakpoint match, cpu clock-enable and next-state selection
    // (halt > step > run when pulses coincide).
    always_comb begin
        match     = bp_en && (pc_in == bp_addr) && !skip;
        cpu_en    = (cur_state == STEP) || ((cur_state == RUN) && !match);
        nxt_state = cur_state;
        skip_set  = 1'b0;
        unique case (cur_state)
            HALT: begin
                if (halt_pulse) begin
                    nxt_state = HALT;
                end else if (step_pulse) begin
                    nxt_state = STEP;
                end else if (run_pulse) begin
                    nxt_state = RUN;
                    skip_set  = 1'b1;
                end
            end
            STEP: begin
                nxt_state = HALT;
            end
            RUN: begin
                if (halt_pulse) begin
                    nxt_state = HALT;
                end else if (match) begin
                    nxt_state = BREAK;
                end
            end
            BREAK: begin
                if (halt_pulse) begin
                    nxt_state = HALT;
                end else if (step_pulse) begin
                    nxt_state = STEP;
                end else if (run_pulse) begin
                    nxt_state = RUN;
                    skip_set  = 1'b1;
                end
            end
            default: nxt_state = HALT;
        endcase
    end

    // Skip flag: suppresses the breakpoint for the first executed RUN cycle after a resume.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            skip <= 1'b0;
        end else if (skip_set) begin
            skip <= 1'b1;
        end else if ((cur_state == RUN) && cpu_en) begin
            skip <= 1'b0;
        end
    end

    // Saturating executed-instruction counter; clear wins over increment.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            instr_count <= '0;
        end else if (clr_count) begin
            instr_count <= '0;
        end else if (cpu_en && (instr_count != '1)) begin
            instr_count <= instr_count + cw'(1);
        end
    end

    assign state  = cur_state;
    assign bp_hit = (cur_state == BREAK);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed vector table, randomized
// stimulus against a behavioural model, and hand sequences for saturation,
// count clear and reset during RUN.
module tb_cpu_run_ctrl;

    localparam int M_HALT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_BREAK = 3;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       btn_run = 1'b0;
    logic       btn_step = 1'b0;
    logic       btn_halt = 1'b0;
    logic       clr_count = 1'b0;
    logic       bp_en = 1'b0;
    logic [4:0] bp_addr = '0;
    logic [4:0] pc_in = '0;

    logic        cpu_en;
    logic [1:0]  state;
    logic        bp_hit;
    logic [15:0] instr_count;
    logic        cpu_en4;
    logic [1:0]  state4;
    logic        bp_hit4;
    logic [3:0]  instr_count4;

    cpu_run_ctrl #(.pw(5), .cw(16)) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .btn_run     (btn_run),
        .btn_step    (btn_step),
        .btn_halt    (btn_halt),
        .clr_count   (clr_count),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc_in       (pc_in),
        .cpu_en      (cpu_en),
        .state       (state),
        .bp_hit      (bp_hit),
        .instr_count (instr_count)
    );

    cpu_run_ctrl #(.pw(5), .cw(4)) dut_sat (
        .clk         (clk),
        .n_reset     (n_reset),
        .btn_run     (btn_run),
        .btn_step    (btn_step),
        .btn_halt    (btn_halt),
        .clr_count   (clr_count),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc_in       (pc_in),
        .cpu_en      (cpu_en4),
        .state       (state4),
        .bp_hit      (bp_hit4),
        .instr_count (instr_count4)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cycle = 0;

    // Behavioural model state
    int          m_mode;
    bit          m_skip;
    int unsigned m_cnt;
    int unsigned m_cnt4;
    int unsigned m_pc;
    bit          hr[1:3];
    bit          hs[1:3];
    bit          hh[1:3];

    // Last observed DUT values
    int obs_state, obs_en, obs_hit, obs_cnt, obs_cnt4;

    typedef struct {
        bit r, s, h;
        int st;
        bit en;
        int cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_HALT;
        m_skip = 1'b0;
        m_cnt  = 0;
        m_cnt4 = 0;
        m_pc   = 0;
        for (int i = 1; i <= 3; i++) begin
            hr[i] = 1'b0;
            hs[i] = 1'b0;
            hh[i] = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs, sample outputs, optionally compare to model, advance model.
    task automatic cyc(input bit r, input bit s, input bit h, input bit cl, input bit be,
                       input logic [4:0] ba, input bit use_model);
        bit pr, ps, ph, mm, me;
        @(negedge clk);
        btn_run   = r;
        btn_step  = s;
        btn_halt  = h;
        clr_count = cl;
        bp_en     = be;
        bp_addr   = ba;
        pc_in     = 5'(m_pc);
        #1;
        // A press reaches the controller two edges after it is first sampled.
        pr = hr[2] & ~hr[3];
        ps = hs[2] & ~hs[3];
        ph = hh[2] & ~hh[3];
        mm = be && (m_pc == 32'(ba)) && !m_skip;
        me = (m_mode == M_STEP) || (m_mode == M_RUN && !mm);
        obs_state = int'(state);
        obs_en    = int'(cpu_en);
        obs_hit   = int'(bp_hit);
        obs_cnt   = int'(instr_count);
        obs_cnt4  = int'(instr_count4);
        if (use_model) begin
            chk("state", obs_state, m_mode);
            chk("cpu_en", obs_en, int'(me));
            chk("bp_hit", obs_hit, int'(m_mode == M_BREAK));
            chk("count", obs_cnt, int'(m_cnt));
            chk("count4", obs_cnt4, int'(m_cnt4));
        end
        @(posedge clk);
        cycle++;
        if (cl) begin
            m_cnt  = 0;
            m_cnt4 = 0;
        end else if (me) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end
        if (me) m_pc = (m_pc + 1) % 32;
        if (me && m_mode == M_RUN) m_skip = 1'b0;
        case (m_mode)
            M_HALT: begin
                if (ph) m_mode = M_HALT;
                else if (ps) m_mode = M_STEP;
                else if (pr) begin m_mode = M_RUN; m_skip = 1'b1; end
            end
            M_STEP: m_mode = M_HALT;
            M_RUN: begin
                if (ph) m_mode = M_HALT;
                else if (mm) m_mode = M_BREAK;
            end
            default: begin
                if (ph) m_mode = M_HALT;
                else if (ps) m_mode = M_STEP;
                else if (pr) begin m_mode = M_RUN; m_skip = 1'b1; end
            end
        endcase
        hr[3] = hr[2]; hr[2] = hr[1]; hr[1] = r;
        hs[3] = hs[2]; hs[2] = hs[1]; hs[1] = s;
        hh[3] = hh[2]; hh[2] = hh[1]; hh[1] = h;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset   = 1'b0;
        btn_run   = 1'b0;
        btn_step  = 1'b0;
        btn_halt  = 1'b0;
        clr_count = 1'b0;
        model_reset();
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic add(input bit r, input bit s, input bit h, input int st, input bit en, input int cnt);
        vec_t v;
        v.r = r; v.s = s; v.h = h; v.st = st; v.en = en; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    initial begin
        bit r, s, h, cl, be;
        logic [4:0] ba;

        model_reset();
        repeat (2) @(negedge clk);
        n_reset = 1'b1;

        // Reset state and idle
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 5'd0, 1'b1);

        // Directed vectors, breakpoint enabled at PC 3 throughout
        add(0,0,0, M_HALT, 0, 0);
        add(0,1,0, M_HALT, 0, 0);
        add(0,0,0, M_HALT, 0, 0);
        add(0,0,0, M_HALT, 0, 0);
        add(0,0,0, M_STEP, 1, 0);
        add(0,0,0, M_HALT, 0, 1);
        add(0,0,0, M_HALT, 0, 1);
        add(1,0,0, M_HALT, 0, 1);
        add(0,0,0, M_HALT, 0, 1);
        add(0,0,0, M_HALT, 0, 1);
        add(0,0,0, M_RUN,  1, 1);
        add(0,0,0, M_RUN,  1, 2);
        add(0,0,0, M_RUN,  0, 3);
        add(0,0,0, M_BREAK,0, 3);
        add(1,0,1, M_BREAK,0, 3);
        add(0,0,0, M_BREAK,0, 3);
        add(0,0,0, M_BREAK,0, 3);
        add(0,0,0, M_HALT, 0, 3);
        add(1,0,0, M_HALT, 0, 3);
        add(0,0,0, M_HALT, 0, 3);
        add(0,0,0, M_HALT, 0, 3);
        add(0,0,0, M_RUN,  1, 3);
        add(0,0,1, M_RUN,  1, 4);
        add(0,0,0, M_RUN,  1, 5);
        add(0,0,0, M_RUN,  1, 6);
        add(0,0,0, M_HALT, 0, 7);
        add(1,1,0, M_HALT, 0, 7);
        add(0,0,0, M_HALT, 0, 7);
        add(0,0,0, M_HALT, 0, 7);
        add(0,0,0, M_STEP, 1, 7);
        add(0,0,0, M_HALT, 0, 8);
        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].h, 0, 1, 5'd3, 1'b0);
            chk($sformatf("vec%0d_state", i), obs_state, tbl[i].st);
            chk($sformatf("vec%0d_en", i), obs_en, int'(tbl[i].en));
            chk($sformatf("vec%0d_hit", i), obs_hit, int'(tbl[i].st == M_BREAK));
            chk($sformatf("vec%0d_cnt", i), obs_cnt, tbl[i].cnt);
        end

        // Randomized stimulus against the model
        be = 1'b1;
        ba = 5'd10;
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 11) == 0);
            h  = ($urandom_range(0, 13) == 0);
            cl = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 49) == 0) be = ~be;
            if ($urandom_range(0, 29) == 0) ba = 5'((m_pc + $urandom_range(0, 6)) % 32);
            cyc(r, s, h, cl, be, ba, 1'b1);
        end

        // Saturation of the narrow counter during a long run
        do_reset();
        cyc(1, 0, 0, 0, 0, 5'd0, 1'b1);
        for (int i = 0; i < 25; i++) cyc(0, 0, 0, 0, 0, 5'd0, 1'b1);
        chk("sat_state", obs_state, M_RUN);
        chk("sat_count4", obs_cnt4, 15);
        chk("sat_count16", obs_cnt, 22);

        // Clear while executing: clear wins over increment
        cyc(0, 0, 0, 1, 0, 5'd0, 1'b1);
        chk("clr_en", obs_en, 1);
        cyc(0, 0, 0, 0, 0, 5'd0, 1'b1);
        chk("clr_count16", obs_cnt, 0);
        chk("clr_count4", obs_cnt4, 0);

        // Asynchronous reset mid-RUN
        cyc(0, 0, 0, 0, 0, 5'd0, 1'b1);
        chk("prereset_en", obs_en, 1);
        @(negedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        chk("rst_en", int'(cpu_en), 0);
        chk("rst_state", int'(state), M_HALT);
        chk("rst_count", int'(instr_count), 0);
        @(posedge clk);
        #1;
        chk("rst_en_hold", int'(cpu_en), 0);
        model_reset();
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 5'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step/halt sequencer for the single-cycle cpu datapath.
- Drives the cpu clock-enable, so the PC and register file advance only when the controller allows it.
- Supports free-running execution, single-step, manual halt, and a hardware PC breakpoint.
- Counts executed instructions.
- Sits between the board buttons/switches and the cpu top level.

Parameters:
pw, 5, PC width (matches cpu pc_out)
cw, 16, executed-instruction counter width

Ports:
clk  input  1  system clock
n_reset  input  1  asynchronous active-low reset
btn_run  input  1  raw run button, asynchronous, active-high
btn_step  input  1  raw step button, asynchronous, active-high
btn_halt  input  1  raw halt button, asynchronous, active-high
clr_count  input  1  synchronous clear of instr_count
bp_en  input  1  breakpoint enable
bp_addr  input  pw  breakpoint PC value
pc_in  input  pw  current cpu PC (c0 pc_out)
cpu_en  output  1  clock-enable for the cpu PC and register-file write
state  output  2  ctrl_state_t encoding of the current state
bp_hit  output  1  high while in BREAK
instr_count  output  cw  instructions executed (cycles with cpu_en=1), saturating

Behaviour:
- Reset (n_reset=0, async):
  - state=HALT, cpu_en=0, bp_hit=0, instr_count=0.
  - All synchroniser flops are cleared.
  - Reset mid-RUN aborts immediately; no further cpu_en pulse.
- Button handling: each btn_* passes through btn_sync (2-flop synchroniser + rising-edge detect).
  - Input first sampled high at edge E0 -> one-cycle pulse between E1 and E2 -> state updates at E2.
  - Holding a button produces exactly one pulse. A new pulse needs a release of at least 1 cycle.
- States: HALT=0, RUN=1, STEP=2, BREAK=3.
- Command priority when pulses coincide: halt > step > run.
- Transitions:
  - HALT: step -> STEP; run -> RESUME action (see below); otherwise stay.
  - STEP: unconditionally -> HALT after 1 cycle. Commands arriving in STEP are dropped.
  - RUN: halt -> HALT; breakpoint match -> BREAK; step ignored; otherwise stay.
  - BREAK: step -> STEP; run -> RUN with skip flag set; halt -> HALT.
- Breakpoint match: match = bp_en && (pc_in == bp_addr) && !skip.
- cpu_en (Mealy): cpu_en = (state==STEP) || (state==RUN && !match).
  - The instruction at bp_addr is NOT executed on entry to BREAK.
- skip flag:
  - Set on BREAK->RUN and on HALT->RUN, so a resume never re-breaks on the current PC.
  - Cleared after the first RUN cycle in which cpu_en=1.
- STEP always executes exactly one instruction, regardless of breakpoint.
- Halt timing: a halt pulse in RUN takes effect at the next edge. The instruction in the pulse cycle still executes (cpu_en stays 1).
- bp_en deasserted while in BREAK: state stays BREAK until a command arrives.
- instr_count:
  - +1 on every edge where cpu_en=1.
  - Saturates at 2^cw-1 (no wrap).
  - clr_count has priority over increment; the value is 0 after that edge.
- PC wrap-around (2^pw-1 -> 0) is transparent; breakpoint compare is pure equality.

Decomposition:
- Package cpu_ctrl_pkg:
  - typedef enum logic [1:0] ctrl_state_t {HALT, RUN, STEP, BREAK}
  - localparam SYNC_STAGES = 2
- Sub-module btn_sync: 2-flop synchroniser + edge detect, one instance per button, reset-clearable.
- cpu_run_ctrl holds the FSM, the skip flag and the counter.

Test Plan:
- Reset, then idle 10 cycles -> state=HALT, cpu_en=0 throughout, instr_count=0.
- Pulse btn_step for 1 cycle -> cpu_en high for exactly 1 cycle, 2 edges after the sample; state STEP->HALT; instr_count=1; cpu pc_out advances 0->1.
- bp_en=1, bp_addr=5, pulse btn_run from PC 0 -> exactly 5 cpu_en cycles; state=BREAK with pc_in=5, bp_hit=1, instr_count=5, r3=65 (PC 5 not executed).
- From BREAK at PC 5, pulse btn_run -> PC 5 executes (no re-break), run continues; pulse btn_halt later -> HALT one edge after the pulse; count equals cpu_en cycles.
- Simultaneous btn_halt+btn_run in HALT -> stays HALT, cpu_en=0. Simultaneous btn_step+btn_run in HALT -> STEP (1 instruction).
- Force instr_count near max (cw=4 build): run 20 cycles -> holds at 15. clr_count with cpu_en=1 -> 0. Assert n_reset low mid-RUN -> cpu_en=0 immediately, state=HALT.
